// File: rtl/ifetch_unit.sv
// ---------------------------------------------------------------------------
// ifetch_unit
//
// Purpose:
//   Simple instruction fetch front end. A program counter walks instruction
//   memory one word per cycle while running, and each fetched word is stored
//   with its address in a 2-entry FIFO that decode drains with a
//   valid/ready handshake. An aligned redirect flushes the FIFO and reloads
//   the PC. A misaligned redirect is rejected and latches a sticky error flag.
//
// Ports:
//   Clk          rising-edge clock
//   Rst_n        asynchronous active-low reset
//   Enable       fetch permitted when high (gates the IDLE/RUN state machine)
//   Address      byte address to instruction memory (current PC)
//   Instruction  instruction memory read data, combinational from Address
//   Redirect     one-cycle request to change the PC
//   RedirectPC   new fetch address, sampled when Redirect=1
//   InstrValid   head FIFO entry is valid
//   InstrReady   decode accepts the head entry this cycle
//   InstrOut     head instruction
//   InstrPC      byte address of the head instruction
//   AlignErr     sticky: a misaligned redirect was rejected
//   FetchCount   number of pushes since reset, wraps at 2^16
// ---------------------------------------------------------------------------
module ifetch_unit #(
    parameter int                  PC_WIDTH = 6,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                Enable,
    output logic [PC_WIDTH-1:0] Address,
    input  logic [31:0]         Instruction,
    input  logic                Redirect,
    input  logic [PC_WIDTH-1:0] RedirectPC,
    output logic                InstrValid,
    input  logic                InstrReady,
    output logic [31:0]         InstrOut,
    output logic [PC_WIDTH-1:0] InstrPC,
    output logic                AlignErr,
    output logic [15:0]         FetchCount
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state;
    state_t              stateNext;
    logic [PC_WIDTH-1:0] pc;
    logic [1:0]          count;
    logic [31:0]         headInstr;
    logic [PC_WIDTH-1:0] headPc;
    logic [31:0]         tailInstr;
    logic [PC_WIDTH-1:0] tailPc;
    logic                push;
    logic                pop;
    logic                redirectTake;
    logic                redirectBad;

    // Next-state and handshake decode. An aligned redirect takes priority
    // over everything else: it blocks both push and pop so the flush leaves
    // the FIFO truly empty. A misaligned redirect is treated as if Redirect
    // were low for data movement and only raises the error flag.
    always_comb begin
        stateNext    = state;
        redirectTake = 1'b0;
        redirectBad  = 1'b0;
        pop          = 1'b0;
        push         = 1'b0;

        case (state)
            IDLE: if (Enable)  stateNext = RUN;
            RUN:  if (!Enable) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase

        redirectTake = Redirect && (RedirectPC[1:0] == 2'b00);
        redirectBad  = Redirect && (RedirectPC[1:0] != 2'b00);
        pop          = (count != 2'd0) && InstrReady && !redirectTake;
        push         = (state == RUN) && !redirectTake && ((count != 2'd2) || pop);
    end

    // State register for the IDLE/RUN machine.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Program counter. Redirect reloads it; a push advances it by one word,
    // wrapping naturally at 2^PC_WIDTH. With the FIFO full and no pop the PC
    // simply holds so the same word is fetched again next cycle.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pc <= RESET_PC;
        end else if (redirectTake) begin
            pc <= RedirectPC;
        end else if (push) begin
            pc <= pc + PC_WIDTH'(4);
        end
    end

    // Two-entry FIFO kept as a head/tail pair so the head drives the outputs
    // directly. Popping shifts tail into head; a push lands in the first free
    // slot, or behind the surviving entry when push and pop coincide.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            count     <= 2'd0;
            headInstr <= '0;
            headPc    <= '0;
            tailInstr <= '0;
            tailPc    <= '0;
        end else if (redirectTake) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        headInstr <= Instruction;
                        headPc    <= pc;
                    end else begin
                        tailInstr <= Instruction;
                        tailPc    <= pc;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    headInstr <= tailInstr;
                    headPc    <= tailPc;
                    count     <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        headInstr <= Instruction;
                        headPc    <= pc;
                    end else begin
                        headInstr <= tailInstr;
                        headPc    <= tailPc;
                        tailInstr <= Instruction;
                        tailPc    <= pc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Sticky misaligned-redirect flag and the running push counter.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            AlignErr   <= 1'b0;
            FetchCount <= 16'd0;
        end else begin
            if (redirectBad) begin
                AlignErr <= 1'b1;
            end
            if (push) begin
                FetchCount <= FetchCount + 16'd1;
            end
        end
    end

    assign Address    = pc;
    assign InstrValid = (count != 2'd0);
    assign InstrOut   = headInstr;
    assign InstrPC    = headPc;

endmodule

// File: tb/tb_ifetch_unit.sv
// ---------------------------------------------------------------------------
// tb_ifetch_unit
//
// Purpose:
//   Self-checking bench for ifetch_unit (PC_WIDTH=6, RESET_PC=0). Instruction
//   memory is modelled as Instruction = 32'hA0000000 | Address. A queue-based
//   reference model tracks the expected FIFO contents, PC, error flag and
//   push count; a compare process checks the DUT against it on every falling
//   edge outside reset. Directed scenarios add literal expectations.
// ---------------------------------------------------------------------------
module tb_ifetch_unit;

    localparam int PC_W = 6;

    logic            Clk;
    logic            Rst_n;
    logic            Enable;
    logic [PC_W-1:0] Address;
    logic [31:0]     Instruction;
    logic            Redirect;
    logic [PC_W-1:0] RedirectPC;
    logic            InstrValid;
    logic            InstrReady;
    logic [31:0]     InstrOut;
    logic [PC_W-1:0] InstrPC;
    logic            AlignErr;
    logic [15:0]     FetchCount;

    int vectors;
    int miscompares;

    typedef struct packed {
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
    } entry_t;

    entry_t mq[$];
    int     mPc;
    bit     mRun;
    bit     mErr;
    int     mFetched;
    bit     doPop;
    bit     doPush;

    ifetch_unit #(
        .PC_WIDTH (PC_W),
        .RESET_PC (6'd0)
    ) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .Enable      (Enable),
        .Address     (Address),
        .Instruction (Instruction),
        .Redirect    (Redirect),
        .RedirectPC  (RedirectPC),
        .InstrValid  (InstrValid),
        .InstrReady  (InstrReady),
        .InstrOut    (InstrOut),
        .InstrPC     (InstrPC),
        .AlignErr    (AlignErr),
        .FetchCount  (FetchCount)
    );

    // Instruction memory: the data word encodes its own address.
    assign Instruction = 32'hA000_0000 | 32'(Address);

    // 100 MHz-style free-running clock, rising edges at 5, 15, 25, ...
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Waits for the next rising edge, then drives the inputs that the
    // following edge will see. On return the outputs reflect the edge just
    // consumed, so literal checks can follow immediately.
    task automatic applyStimulus(input logic en, input logic redir,
                                 input logic [PC_W-1:0] rpc, input logic rdy);
        @(posedge Clk);
        #1;
        Enable     = en;
        Redirect   = redir;
        RedirectPC = rpc;
        InstrReady = rdy;
    endtask

    // Asserts reset shortly after a rising edge, checks that every output
    // clears without any clock edge, and releases it before the next edge.
    task automatic resetDut(input logic en, input logic rdy);
        @(posedge Clk);
        #2;
        Rst_n      = 1'b0;
        Enable     = en;
        InstrReady = rdy;
        Redirect   = 1'b0;
        RedirectPC = '0;
        #1;
        checkOutput("rst_valid", 32'(InstrValid), 32'd0);
        checkOutput("rst_instr", InstrOut, 32'd0);
        checkOutput("rst_ipc",   32'(InstrPC), 32'd0);
        checkOutput("rst_addr",  32'(Address), 32'd0);
        checkOutput("rst_alerr", 32'(AlignErr), 32'd0);
        checkOutput("rst_fcnt",  32'(FetchCount), 32'd0);
        @(negedge Clk);
        #2;
        Rst_n = 1'b1;
    endtask

    // Reference model: evaluates the fetch rules once per rising edge using
    // a queue for the buffer and plain integer arithmetic for the PC.
    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            mq.delete();
            mPc      = 0;
            mRun     = 1'b0;
            mErr     = 1'b0;
            mFetched = 0;
        end else begin
            if (Redirect && (RedirectPC % 4 == 0)) begin
                mq.delete();
                mPc = int'(RedirectPC);
            end else begin
                if (Redirect) mErr = 1'b1;
                doPop  = (mq.size() > 0) && InstrReady;
                doPush = mRun && ((mq.size() < 2) || doPop);
                if (doPop) void'(mq.pop_front());
                if (doPush) begin
                    mq.push_back({32'hA000_0000 | 32'(mPc), PC_W'(mPc)});
                    mPc      = (mPc + 4) % (1 << PC_W);
                    mFetched = mFetched + 1;
                end
            end
            mRun = Enable;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge Clk) begin
        if (Rst_n) begin
            checkOutput("valid", 32'(InstrValid), 32'(mq.size() > 0));
            if (mq.size() > 0) begin
                checkOutput("instr", InstrOut, mq[0].instr);
                checkOutput("ipc",   32'(InstrPC), 32'(mq[0].pc));
            end
            checkOutput("addr",  32'(Address), 32'(mPc));
            checkOutput("alerr", 32'(AlignErr), 32'(mErr));
            checkOutput("fcnt",  32'(FetchCount), 32'(mFetched % 65536));
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        Rst_n       = 1'b1;
        Enable      = 1'b0;
        Redirect    = 1'b0;
        RedirectPC  = '0;
        InstrReady  = 1'b0;

        // Streaming from reset: one instruction per cycle.
        resetDut(1'b1, 1'b1);
        applyStimulus(1, 0, 6'h00, 1);
        checkOutput("s1_valid0", 32'(InstrValid), 32'd0);
        applyStimulus(1, 0, 6'h00, 1);
        checkOutput("s1_instr0", InstrOut, 32'hA000_0000);
        checkOutput("s1_ipc0",   32'(InstrPC), 32'h00);
        checkOutput("s1_fcnt1",  32'(FetchCount), 32'd1);
        applyStimulus(1, 0, 6'h00, 1);
        checkOutput("s1_instr4", InstrOut, 32'hA000_0004);
        applyStimulus(1, 0, 6'h00, 1);
        checkOutput("s1_instr8", InstrOut, 32'hA000_0008);
        checkOutput("s1_addr",   32'(Address), 32'h0C);
        checkOutput("s1_fcnt3",  32'(FetchCount), 32'd3);

        // Back-pressure: FIFO fills to two entries and the PC holds.
        resetDut(1'b1, 1'b0);
        applyStimulus(1, 0, 6'h00, 0);
        applyStimulus(1, 0, 6'h00, 0);
        checkOutput("s2_ipc0",  32'(InstrPC), 32'h00);
        checkOutput("s2_addr4", 32'(Address), 32'h04);
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 6'h00, 0);
        applyStimulus(1, 0, 6'h00, 1);
        checkOutput("s2_addr8", 32'(Address), 32'h08);
        checkOutput("s2_fcnt2", 32'(FetchCount), 32'd2);
        checkOutput("s2_hold",  InstrOut, 32'hA000_0000);
        applyStimulus(1, 0, 6'h00, 1);
        checkOutput("s2_ipc4",  32'(InstrPC), 32'h04);
        applyStimulus(1, 0, 6'h00, 1);
        checkOutput("s2_ipc8",  32'(InstrPC), 32'h08);
        applyStimulus(1, 0, 6'h00, 1);
        checkOutput("s2_ipc12", 32'(InstrPC), 32'h0C);

        // Aligned redirect with a full FIFO.
        applyStimulus(1, 1, 6'h24, 1);
        checkOutput("s3_ipc16", 32'(InstrPC), 32'h10);
        applyStimulus(1, 0, 6'h00, 1);
        checkOutput("s3_flush", 32'(InstrValid), 32'd0);
        checkOutput("s3_addr",  32'(Address), 32'h24);
        applyStimulus(1, 0, 6'h00, 1);
        checkOutput("s3_instr", InstrOut, 32'hA000_0024);
        checkOutput("s3_ipc",   32'(InstrPC), 32'h24);

        // Misaligned redirect is ignored but flagged; the flag is sticky.
        applyStimulus(1, 1, 6'h26, 1);
        applyStimulus(1, 0, 6'h00, 1);
        checkOutput("s4_alerr", 32'(AlignErr), 32'd1);
        checkOutput("s4_ipc",   32'(InstrPC), 32'h2C);
        applyStimulus(1, 1, 6'h38, 1);
        applyStimulus(1, 0, 6'h00, 1);
        checkOutput("s4_sticky", 32'(AlignErr), 32'd1);
        checkOutput("s4_flush",  32'(InstrValid), 32'd0);

        // PC wrap at 2^6.
        applyStimulus(1, 0, 6'h00, 1);
        checkOutput("s5_ipc38", 32'(InstrPC), 32'h38);
        applyStimulus(1, 0, 6'h00, 1);
        checkOutput("s5_ipc3c", 32'(InstrPC), 32'h3C);
        applyStimulus(1, 0, 6'h00, 1);
        checkOutput("s5_ipc00", 32'(InstrPC), 32'h00);
        applyStimulus(1, 0, 6'h00, 1);
        checkOutput("s5_ipc04", 32'(InstrPC), 32'h04);

        // Reset mid-stream, restart from address 0.
        resetDut(1'b1, 1'b1);
        applyStimulus(1, 0, 6'h00, 1);
        applyStimulus(1, 0, 6'h00, 0);
        checkOutput("s6_instr", InstrOut, 32'hA000_0000);
        checkOutput("s6_fcnt",  32'(FetchCount), 32'd1);
        checkOutput("s6_alerr", 32'(AlignErr), 32'd0);

        // Dropping Enable stops fetch but the FIFO still drains.
        applyStimulus(0, 0, 6'h00, 1);
        applyStimulus(0, 0, 6'h00, 1);
        applyStimulus(0, 0, 6'h00, 1);
        applyStimulus(0, 0, 6'h00, 1);
        checkOutput("s7_empty", 32'(InstrValid), 32'd0);
        checkOutput("s7_addr",  32'(Address), 32'h0C);
        checkOutput("s7_fcnt",  32'(FetchCount), 32'd3);
        applyStimulus(0, 0, 6'h00, 1);
        checkOutput("s7_hold",  32'(Address), 32'h0C);

        @(negedge Clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 6, which sets the byte-address width of the program counter.
REQ-002 SHALL have parameter RESET_PC, default 0, which is the fetch address after reset; it SHALL be word-aligned.
REQ-003 SHALL use one clock and an asynchronous, active-low reset. Ports: Clk and Rst_n.
REQ-004 Clk  input  1  rising-edge clock.
REQ-005 Rst_n  input  1  asynchronous active-low reset.
REQ-006 Enable  input  1  fetch permitted when high.
REQ-007 Address  output  PC_WIDTH  byte address to the instruction memory; equals the current PC.
REQ-008 Instruction  input  32  instruction memory read data; combinational from Address, valid in the same cycle.
REQ-009 Redirect  input  1  one-cycle request to change the PC (branch/jump/exception).
REQ-010 RedirectPC  input  PC_WIDTH  new fetch address, sampled when Redirect=1.
REQ-011 InstrValid  output  1  InstrOut/InstrPC hold a valid entry.
REQ-012 InstrReady  input  1  decode accepts the head entry.
REQ-013 InstrOut  output  32  head instruction.
REQ-014 InstrPC  output  PC_WIDTH  byte address of the head instruction.
REQ-015 AlignErr  output  1  sticky flag: a misaligned redirect was rejected.
REQ-016 FetchCount  output  16  number of instructions pushed since reset; wraps at 2^16.

Function
REQ-017 FSM states: IDLE and RUN. IDLE->RUN when Enable=1. RUN->IDLE when Enable=0. Transitions SHALL take effect at the clock edge.
REQ-018 Buffer: 2-entry FIFO of {Instruction, PC}. Pop SHALL occur when InstrValid=1 and InstrReady=1.
REQ-019 Push condition: state=RUN, Redirect=0, and (FIFO count<2 or pop this cycle). On push, the FIFO SHALL capture {Instruction, Address} and PC SHALL advance to PC+4.
REQ-020 PC arithmetic SHALL be modulo 2^PC_WIDTH; with PC_WIDTH=6, PC 60 SHALL advance to 0.
REQ-021 Latency: an instruction pushed at edge N SHALL be visible on InstrOut with InstrValid=1 in cycle N+1 if the FIFO was empty.
REQ-022 InstrOut/InstrPC SHALL be stable while InstrValid=1 and InstrReady=0.
REQ-023 FIFO full with no pop: no push, PC held, Address unchanged.
REQ-024 Simultaneous push and pop when full SHALL be allowed; count stays 2 and order is preserved.
REQ-025 Aligned redirect (RedirectPC[1:0]=0): at the edge, the FIFO SHALL be flushed (count=0), PC SHALL become RedirectPC, and there SHALL be no push or pop that cycle. InstrValid SHALL be 0 in the next cycle. This applies in both IDLE and RUN.
REQ-026 Misaligned redirect (RedirectPC[1:0]!=0): the redirect SHALL be ignored (no flush, normal push/pop), and AlignErr SHALL be set to 1 until reset.
REQ-027 Enable=0 SHALL stop pushes only; pops SHALL continue to drain the FIFO.
REQ-028 FetchCount SHALL increment by 1 on each push.

Reset
REQ-029 While Rst_n=0, the following SHALL hold immediately, regardless of Clk: state=IDLE, PC=RESET_PC, FIFO count=0, InstrValid=0, InstrOut=0, InstrPC=0, AlignErr=0, FetchCount=0.
REQ-030 Reset asserted mid-fetch SHALL discard all buffered entries. The first push after release SHALL be at RESET_PC.

Verification
Bench memory model for all scenarios: Instruction = 32'hA0000000 | Address.
REQ-031 Reset release with Enable=1 and InstrReady=1 -> InstrOut sequence A0000000, A0000004, A0000008, ... with one instruction per cycle, and InstrPC matching each entry.
REQ-032 InstrReady=0 for 5 cycles after the first push -> exactly 2 entries buffered (PC 0, 4), Address holds at 8. Then InstrReady=1 -> entries 0, 4, 8 are delivered in order with no gap and no duplicate.
REQ-033 Redirect=1 with RedirectPC=0x24 while the FIFO holds 2 entries -> next cycle InstrValid=0; the following cycle InstrOut=A0000024 and InstrPC=0x24.
REQ-034 Redirect=1 with RedirectPC=0x26 -> AlignErr=1, fetch stream continues unchanged, and AlignErr stays 1 through later aligned redirects.
REQ-035 Run from PC=0x38 with PC_WIDTH=6 -> InstrPC sequence 0x38, 0x3C, 0x00, 0x04. Also: Rst_n pulsed low mid-stream -> outputs zero asynchronously, and the stream restarts at 0 with FetchCount=1 after the first push.
